axi_master_write: RTL
=====================

AXI_MASTER_WRITE -- requirements
Module: axi_master_write

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0, value driven on AWID.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, number of posted-write buffer entries (power of two, 2..8), used only when WRITE_BUFFER_EN is defined.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  CPU store request.
REQ-006 req_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 req_data  input  32  store data.
REQ-008 req_strb  input  4  byte strobes, active-high.
REQ-009 req_ready  output  1  request accepted this cycle; CPU holds the request while low.
REQ-010 busy  output  1  any write accepted but not yet responded.
REQ-011 bus_err  output  1  sticky, set on non-OKAY BRESP.
REQ-012 AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  output  4/32/4/3/2/1  AXI write address; AWREADY input 1.
REQ-013 WDATA/WSTRB/WLAST/WVALID  output  32/4/1/1  AXI write data; WREADY input 1.
REQ-014 BID/BRESP/BVALID  input  4/2/1  AXI write response; BREADY output 1.

Function
REQ-015 Every transaction SHALL be single-beat: AWLEN=0, AWSIZE=3'b010, AWBURST=INCR, WLAST=1 whenever WVALID=1, AWADDR={addr[31:2],2'b00}.
REQ-016 The FSM SHALL have states IDLE, SEND and RESP.
REQ-017 IDLE -> SEND when a write is pending; AWVALID and WVALID both assert in the first SEND cycle.
REQ-018 In SEND, the aw_done and w_done flags SHALL latch the AW and W handshakes independently. After its handshake, AWVALID or WVALID respectively SHALL deassert on the next cycle.
REQ-019 SEND -> RESP in the cycle in which the last outstanding AW/W handshake completes; AW and W completing in the same cycle SHALL also be legal.
REQ-020 In RESP, BREADY SHALL be 1. On BVALID, the FSM SHALL go to IDLE, or to SEND if another write is pending (no idle bubble).
REQ-021 Once asserted, AWVALID and WVALID SHALL hold address, data and strobe stable until their handshake completes.
REQ-022 bus_err SHALL set when BVALID&BREADY and BRESP!=2'b00, or BID!=MASTER_ID. It SHALL clear only on reset.
REQ-023 When req_strb=4'b0000, the request SHALL be accepted and completed with no AXI traffic.
REQ-024 busy = (state!=IDLE) | buffer non-empty.

Reset
REQ-025 On reset: state=IDLE, aw_done=w_done=0, buffer empty, bus_err=0, AWVALID=WVALID=0, BREADY=0, req_ready=0, busy=0, and all AXI payload outputs 0.
REQ-026 Reset during SEND or RESP SHALL abandon the transaction immediately; no AXI valid shall be driven in the first cycle after deassertion.

Configuration
REQ-027 Macro WRITE_BUFFER_EN defined: writes SHALL be posted into a BUF_DEPTH-entry FIFO. req_ready=!full. The FSM SHALL drain the FIFO in order. Accept and drain in the same cycle while full SHALL be allowed.
REQ-028 WRITE_BUFFER_EN undefined: there SHALL be no FIFO. req_ready SHALL pulse for one cycle when BVALID&BREADY completes the request being held. The CPU stalls for the full round trip.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef, the AXI_RESP_OKAY/AXI_BURST_INCR/AXI_SIZE_WORD constants, and the request struct {addr,data,strb}.
REQ-030 Under WRITE_BUFFER_EN, one sub-module SHALL be instantiated: write_req_fifo (synchronous FIFO with full/empty, async active-low reset).

Verification
REQ-031 A write to 0x0000_1004, data 0xDEADBEEF, strb 0xF, with AWREADY=WREADY=1 SHALL give AW+W handshakes in SEND cycle 1; BVALID two cycles later gives BRESP=0, bus_err=0, and the FSM returns to IDLE.
REQ-032 AWREADY delayed 3 cycles with WREADY=1 SHALL make WVALID drop after 1 cycle while AWVALID holds a stable 0x1004; RESP is entered only after AW completes.
REQ-033 BRESP=2'b10 on any write SHALL set bus_err=1, which stays 1 across 10 further OKAY writes until reset.
REQ-034 With WRITE_BUFFER_EN, BUF_DEPTH=2 and 4 back-to-back requests while AWREADY=0: req_ready SHALL drop after 2 accepts; the AXI order observed is addresses 0x0,0x4,0x8,0xC.
REQ-035 Reset asserted mid-SEND with AWVALID=1 SHALL drive AWVALID=0 asynchronously and leave busy=0 and the buffer empty.
REQ-036 strb=4'b0000 SHALL produce no AWVALID assertion; req_ready follows REQ-027/REQ-028.

Source files
------------

// File: rtl/axi_master_write_pkg.sv
// Shared types and constants for the single-beat AXI write master.
package axi_master_write_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

endpackage

// File: rtl/axi_master_write_fifo.sv
// write_req_fifo: synchronous FIFO of posted store requests (async active-low reset).
// Used by axi_master_write only when WRITE_BUFFER_EN is defined.
module write_req_fifo
  import axi_master_write_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  wr_req_t                    din,
  output wr_req_t                    dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  wr_req_t         mem_q [DEPTH];
  wr_req_t         mem_d [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]     count_q, count_d;

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state is reset; storage is not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/axi_master_write.sv
// axi_master_write: turns CPU store requests into single-beat AXI4 writes.
// Optional macro WRITE_BUFFER_EN posts stores into a BUF_DEPTH-entry FIFO;
// without it the CPU is held until the write response returns.
module axi_master_write
  import axi_master_write_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strb,
  output logic        req_ready,
  output logic        busy,
  output logic        bus_err,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t  state_q, state_d;
  logic    aw_done_q, aw_done_d;
  logic    w_done_q, w_done_d;
  logic    bus_err_q, bus_err_d;

  wr_req_t req_in;
  wr_req_t head;
  logic    pending;
  logic    pending_after;
  logic    aw_hs, w_hs, b_hs;

  assign req_in = '{addr: req_addr, data: req_data, strb: req_strb};
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;

`ifdef WRITE_BUFFER_EN
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic          fifo_full, fifo_empty, push, pop, accept_ok;
  logic [CW-1:0] fifo_count;

  // Head entry stays in the FIFO while in flight and is popped by its response,
  // so a full FIFO can still accept in the cycle it drains. Zero-strobe stores
  // are accepted but never queued.
  assign pop           = b_hs;
  assign accept_ok     = !fifo_full | pop;
  assign push          = req_valid & accept_ok & (req_strb != 4'b0000);
  assign req_ready     = reset & accept_ok;
  assign pending       = !fifo_empty;
  assign pending_after = (|fifo_count[CW-1:1]) | push;
  assign busy          = (state_q != ST_IDLE) | !fifo_empty;

  write_req_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
`else
  // The CPU holds the request, so it is its own payload source. Zero-strobe
  // stores complete at once in IDLE; others release the CPU on the response.
  assign head          = req_in;
  assign pending       = req_valid & (req_strb != 4'b0000);
  assign pending_after = 1'b0;
  assign req_ready     = reset & ((state_q == ST_IDLE & req_valid & (req_strb == 4'b0000)) | b_hs);
  assign busy          = (state_q != ST_IDLE);
`endif

  // State register and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state: AW and W complete independently; leave SEND once both are done.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          state_d   = ST_SEND;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = ST_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          state_d = pending_after ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (b_hs && ((bresp != AXI_RESP_OKAY) || (bid != MASTER_ID))) begin
      bus_err_d = 1'b1;
    end
  end

  // AXI outputs: payload only driven while sending, zero otherwise.
  always_comb begin
    awid    = '0;
    awaddr  = '0;
    awlen   = '0;
    awsize  = '0;
    awburst = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    if (state_q == ST_SEND) begin
      awid    = MASTER_ID;
      awaddr  = head.addr & 32'hFFFF_FFFC;
      awlen   = 4'd0;
      awsize  = AXI_SIZE_WORD;
      awburst = AXI_BURST_INCR;
      awvalid = !aw_done_q;
      wdata   = head.data;
      wstrb   = head.strb;
      wvalid  = !w_done_q;
      wlast   = !w_done_q;
    end
    if (state_q == ST_RESP) begin
      bready = 1'b1;
    end
  end

  assign bus_err = bus_err_q;

endmodule
